dma_priority_arbiter: RTL

// - N-channel DMA request arbiter with hold handshake; generalises the 4-channel 8237-style priority logic.
// - Resolves unmasked DREQ/software requests in fixed or rotating priority and runs the HRQ/HLDA bus-hold handshake.
// - Drives one-hot DACK for the winning channel and reports the winner to timing control (state SO..S4).
// - Sits between the DREQ pins/request and mask registers and the transfer timing state machine.

---
 rtl/dma_priority_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/dma_priority_arbiter.sv
// N-channel DMA request arbiter: resolves unmasked hardware/software requests
// in fixed or rotating priority, runs the HRQ/HLDA bus-hold handshake and
// drives a one-hot DACK for the winning channel.
//
// Handshake: HRQ is raised one cycle after a request is seen in IDLE.
// HRQ stays high until the service completes (svcDone) or no request is left
// when HLDA arrives. After HRQ drops, the block waits for HLDA to fall before
// it can raise HRQ again. The grant is taken on the cycle HLDA is sampled high
// in REQ. svcDone is honoured only while a channel is granted.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] swReq,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              priorityType,
    input  logic              dreqSense,
    input  logic              dackSense,
    input  logic              ctrlDisable,
    input  logic              HLDA,
    input  logic              svcDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantCh,
    output logic [CH_W-1:0]   priorityPtr,
    output logic [1:0]        stateDbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t state;

    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   searchPtr;
    logic              winFound;
    logic [CH_W-1:0]   winIdx;
    logic [CH_W-1:0]   nextPtr;
    logic [NUM_CH-1:0] dackActive;

    // Effective request vector: sense-corrected DREQ or software request, unless masked
    always_comb begin
        req = ~maskReg & ((DREQ ^ {NUM_CH{dreqSense}}) | swReq);
    end

    // Circular search from the highest-priority channel; fixed mode always starts at 0
    always_comb begin
        int idx;
        searchPtr = priorityType ? priorityPtr : '0;
        winFound  = 1'b0;
        winIdx    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(searchPtr) + k) % NUM_CH;
            if (!winFound && req[idx]) begin
                winFound = 1'b1;
                winIdx   = CH_W'(idx);
            end
        end
    end

    // Served channel becomes lowest priority: pointer moves just past it, wrapping
    always_comb begin
        if (grantCh == CH_W'(NUM_CH - 1)) begin
            nextPtr = '0;
        end else begin
            nextPtr = grantCh + CH_W'(1);
        end
    end

    // One-hot acknowledge decoded from the registered grant; polarity follows dackSense live
    always_comb begin
        dackActive = '0;
        if (grantValid) begin
            dackActive = {{(NUM_CH-1){1'b0}}, 1'b1} << grantCh;
        end
        DACK = dackSense ? dackActive : ~dackActive;
    end

    // Handshake FSM with registered HRQ, grant and priority pointer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            HRQ         <= 1'b0;
            grantValid  <= 1'b0;
            grantCh     <= '0;
            priorityPtr <= '0;
        end else begin
            if (!priorityType) begin
                priorityPtr <= '0;
            end
            case (state)
                IDLE: begin
                    if (|req && !ctrlDisable) begin
                        state <= REQ;
                        HRQ   <= 1'b1;
                    end
                end
                REQ: begin
                    if (HLDA) begin
                        if (winFound) begin
                            state      <= GRANT;
                            grantCh    <= winIdx;
                            grantValid <= 1'b1;
                        end else begin
                            state <= RELEASE;
                            HRQ   <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    if (svcDone) begin
                        state      <= RELEASE;
                        grantValid <= 1'b0;
                        HRQ        <= 1'b0;
                        if (priorityType) begin
                            priorityPtr <= nextPtr;
                        end
                    end
                end
                RELEASE: begin
                    if (!HLDA) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    HRQ        <= 1'b0;
                    grantValid <= 1'b0;
                end
            endcase
        end
    end

    // Current state exposed for observation
    always_comb begin
        stateDbg = state;
    end

endmodule
